// File: rtl/slow_seq.sv
// Fast/slow CPU clock switch sequencer for accesses to legacy peripherals.
// Optional access statistics are enabled with the SLOW_SEQ_STATS_EN macro.
module slow_seq #(
    parameter int TW      = 8,
    parameter int MINHOLD = 2
) (
    input  logic          CLK,
    input  logic          POR,
    input  logic          BACT,
    input  logic          IACKCS,
    input  logic          VIACS,
    input  logic          IWMCS,
    input  logic          SCCCS,
    input  logic          SCSICS,
    input  logic          SndCS,
    input  logic          SlowIACK,
    input  logic          SlowVIA,
    input  logic          SlowIWM,
    input  logic          SlowSCC,
    input  logic          SlowSCSI,
    input  logic          SlowSnd,
    input  logic          SlowClockGate,
    input  logic [3:0]    SlowTimeout,
    input  logic          Tick,
    input  logic          SlowAck,
    output logic          SlowReq,
    output logic          Stall,
    output logic          ClockGate,
    output logic          SlowActive,
    output logic [15:0]   SlowAccCnt,
    output logic [2:0]    dbg_state,
    output logic [TW-1:0] dbg_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        ACCESS  = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic          bact_r;
    logic [TW-1:0] cnt, cnt_n;
    logic [TW-1:0] load_val;
    logic          deferred, deferred_n;
    logic          hit, start, take;

    assign hit = BACT & |{IACKCS & SlowIACK, VIACS & SlowVIA, IWMCS & SlowIWM,
                          SCCCS & SlowSCC, SCSICS & SlowSCSI, SndCS & SlowSnd};
    // A bus cycle is judged only on its first CLK with BACT high.
    assign start = BACT & ~bact_r & hit;

    always_comb begin
        load_val = {SlowTimeout, {(TW-4){1'b1}}};
        if (SlowTimeout == 4'd0)
            load_val = TW'(MINHOLD);
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        deferred_n = deferred;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SYNC;
                    take    = 1'b1;
                end
            end
            SYNC: begin
                // An aborted cycle still leaves the switcher in slow mode, so hold.
                if (!BACT) begin
                    state_n = HOLD;
                    cnt_n   = load_val;
                end else if (SlowAck) begin
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (!BACT) begin
                    state_n = HOLD;
                    cnt_n   = load_val;
                end
            end
            HOLD: begin
                if (start) begin
                    state_n = ACCESS;
                    take    = 1'b1;
                end else if (cnt == '0) begin
                    state_n = RELEASE;
                end else if (Tick) begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RELEASE: begin
                if (start)
                    deferred_n = 1'b1;
                else if (!BACT)
                    deferred_n = 1'b0;
                if (!SlowAck) begin
                    if (deferred_n) begin
                        state_n    = SYNC;
                        take       = 1'b1;
                        deferred_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            state    <= IDLE;
            cnt      <= '0;
            bact_r   <= 1'b0;
            deferred <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bact_r   <= BACT;
            deferred <= deferred_n;
        end
    end

    // Outputs are registered from the next-state so they line up with the state register.
    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            SlowReq    <= 1'b0;
            Stall      <= 1'b0;
            ClockGate  <= 1'b0;
            SlowActive <= 1'b0;
        end else begin
            SlowReq    <= (state_n == SYNC) || (state_n == ACCESS) || (state_n == HOLD);
            Stall      <= (state_n == SYNC) || ((state_n == RELEASE) && deferred_n);
            ClockGate  <= SlowClockGate & SlowReq & SlowAck;
            SlowActive <= (state_n != IDLE);
        end
    end

    assign dbg_state = state;
    assign dbg_cnt   = cnt;

`ifdef SLOW_SEQ_STATS_EN
    logic [15:0] acc_cnt;

    always_ff @(posedge CLK or posedge POR) begin
        if (POR)
            acc_cnt <= '0;
        else if (take && (acc_cnt != 16'hFFFF))
            acc_cnt <= acc_cnt + 16'd1;
    end

    assign SlowAccCnt = acc_cnt;
`else
    logic unused_take;
    assign unused_take = take;
    assign SlowAccCnt  = '0;
`endif

endmodule
